// File: rtl/apple_spawner_pkg.sv
// rtl/apple_spawner_pkg.sv - shared grid defaults, widths, FSM states and LFSR step
package apple_spawner_pkg;

  localparam int GRID_COLS_DEF = 40;
  localparam int GRID_ROWS_DEF = 30;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam int MAX_DRAWS_DEF = 16;

  localparam int X_W = 7;
  localparam int Y_W = 6;
  localparam int P_W = 13;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_CHECK,
    ST_WAIT
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/apple_spawner_lfsr16.sv
// rtl/apple_spawner_lfsr16.sv - free-running 16-bit Fibonacci LFSR
module apple_spawner_lfsr16
  import apple_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge pclk_i) begin
    if (!rst_i) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/apple_spawner.sv
// rtl/apple_spawner.sv - random apple placement with linear probing around snake occupancy
module apple_spawner
  import apple_spawner_pkg::*;
#(
  parameter int          GRID_COLS = GRID_COLS_DEF,
  parameter int          GRID_ROWS = GRID_ROWS_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter int          MAX_DRAWS = MAX_DRAWS_DEF
) (
  input  logic       pclk_i,
  input  logic       rst_i,
  input  logic       spawn_req_i,
  output logic       chk_req_o,
  output logic [6:0] chk_x_o,
  output logic [5:0] chk_y_o,
  input  logic       chk_done_i,
  input  logic       chk_hit_i,
  output logic [6:0] apple_x_o,
  output logic [5:0] apple_y_o,
  output logic       apple_valid_o,
  output logic       spawn_done_o,
  output logic       board_full_o,
  output logic       busy_o
);

  localparam int DRAW_W = $clog2(MAX_DRAWS + 1);
  localparam logic [X_W-1:0]    MAX_X      = X_W'(GRID_COLS - 1);
  localparam logic [Y_W-1:0]    MAX_Y      = Y_W'(GRID_ROWS - 1);
  localparam logic [P_W-1:0]    CELLS_LAST = P_W'(GRID_COLS * GRID_ROWS - 1);
  localparam logic [DRAW_W-1:0] DRAWS_LAST = DRAW_W'(MAX_DRAWS - 1);

  logic [15:0] lfsr;
  logic        unused_lfsr_bits;

  apple_spawner_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .pclk_i (pclk_i),
    .rst_i  (rst_i),
    .q_o    (lfsr)
  );

  assign unused_lfsr_bits = ^{lfsr[15:14], lfsr[7]};

  state_e            state_q;
  logic [DRAW_W-1:0] draws_q;
  logic [P_W-1:0]    probes_q;
  logic [X_W-1:0]    chk_x_q, apple_x_q, probe_x_d, cand_x;
  logic [Y_W-1:0]    chk_y_q, apple_y_q, probe_y_d, cand_y;
  logic              chk_req_q, apple_valid_q, spawn_done_q, board_full_q, busy_q;
  logic              cand_ok;

  assign cand_x  = lfsr[6:0];
  assign cand_y  = lfsr[13:8];
  assign cand_ok = (cand_x <= MAX_X) && (cand_y <= MAX_Y);

  // Raster-order successor of the current probe cell, wrapping at both edges
  always_comb begin
    probe_x_d = chk_x_q + 1'b1;
    probe_y_d = chk_y_q;
    if (chk_x_q == MAX_X) begin
      probe_x_d = '0;
      probe_y_d = (chk_y_q == MAX_Y) ? '0 : chk_y_q + 1'b1;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      draws_q       <= '0;
      probes_q      <= '0;
      chk_x_q       <= '0;
      chk_y_q       <= '0;
      apple_x_q     <= '0;
      apple_y_q     <= '0;
      chk_req_q     <= 1'b0;
      apple_valid_q <= 1'b0;
      spawn_done_q  <= 1'b0;
      board_full_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      chk_req_q    <= 1'b0;
      spawn_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (spawn_req_i) begin
          state_q       <= ST_DRAW;
          busy_q        <= 1'b1;
          board_full_q  <= 1'b0;
          apple_valid_q <= 1'b0;
          draws_q       <= '0;
          probes_q      <= '0;
        end
        ST_DRAW: begin
          if (cand_ok || draws_q == DRAWS_LAST) begin
            chk_x_q   <= cand_ok ? cand_x : '0;
            chk_y_q   <= cand_ok ? cand_y : '0;
            chk_req_q <= 1'b1;
            state_q   <= ST_CHECK;
          end else begin
            draws_q <= draws_q + 1'b1;
          end
        end
        ST_CHECK: state_q <= ST_WAIT;
        ST_WAIT: if (chk_done_i) begin
          if (!chk_hit_i) begin
            apple_x_q     <= chk_x_q;
            apple_y_q     <= chk_y_q;
            apple_valid_q <= 1'b1;
            spawn_done_q  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else if (probes_q == CELLS_LAST) begin
            board_full_q  <= 1'b1;
            apple_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            probes_q  <= probes_q + 1'b1;
            chk_x_q   <= probe_x_d;
            chk_y_q   <= probe_y_d;
            chk_req_q <= 1'b1;
            state_q   <= ST_CHECK;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign chk_req_o     = chk_req_q;
  assign chk_x_o       = chk_x_q;
  assign chk_y_o       = chk_y_q;
  assign apple_x_o     = apple_x_q;
  assign apple_y_o     = apple_y_q;
  assign apple_valid_o = apple_valid_q;
  assign spawn_done_o  = spawn_done_q;
  assign board_full_o  = board_full_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_apple_spawner.sv
// tb/tb_apple_spawner.sv - directed self-checking bench for apple_spawner
module tb_apple_spawner;

  logic       pclk, rst, spawn_req, chk_done, chk_hit;
  logic       chk_req, apple_valid, spawn_done, board_full, busy;
  logic [6:0] chk_x, apple_x;
  logic [5:0] chk_y, apple_y;

  logic resp_done, resp_hit, stray_done;
  int   mode, lat, pend, n_req, n_done, checks, failures;
  logic [6:0] qx[$];
  logic [5:0] qy[$];
  logic [6:0] cur_x;
  logic [5:0] cur_y;

  assign chk_done = resp_done | stray_done;
  assign chk_hit  = resp_hit;

  // Seed chosen so the first draw after reset release is cell (39,29)
  apple_spawner #(.LFSR_SEED(16'h0E93)) dut (
    .pclk_i(pclk), .rst_i(rst), .spawn_req_i(spawn_req),
    .chk_req_o(chk_req), .chk_x_o(chk_x), .chk_y_o(chk_y),
    .chk_done_i(chk_done), .chk_hit_i(chk_hit),
    .apple_x_o(apple_x), .apple_y_o(apple_y), .apple_valid_o(apple_valid),
    .spawn_done_o(spawn_done), .board_full_o(board_full), .busy_o(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic hit_for(input logic [6:0] x, input logic [5:0] y);
    if (mode == 2) return 1'b1;
    if (mode == 1) return (x == 7'd39 && y == 6'd29);
    return 1'b0;
  endfunction

  // Occupancy checker model: answers each query lat cycles later
  initial begin resp_done = 1'b0; resp_hit = 1'b0; pend = 0; n_req = 0; n_done = 0; end
  always @(negedge pclk) begin
    resp_done = 1'b0;
    resp_hit  = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin resp_done = 1'b1; resp_hit = hit_for(cur_x, cur_y); end
    end
    if (chk_req === 1'b1) begin
      n_req = n_req + 1;
      qx.push_back(chk_x);
      qy.push_back(chk_y);
      cur_x = chk_x;
      cur_y = chk_y;
      pend  = lat;
    end
    if (spawn_done === 1'b1) n_done = n_done + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(negedge pclk); #1; end
  endtask

  task automatic pulse_spawn();
    spawn_req = 1'b1; tick(1); spawn_req = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin tick(1); if (spawn_done === 1'b1) ok = 1'b1; end
  endtask

  task automatic wait_chk_req(input int max, output bit ok);
    ok = (chk_req === 1'b1);
    for (int i = 0; i < max && !ok; i++) begin tick(1); if (chk_req === 1'b1) ok = 1'b1; end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = (busy === 1'b0);
    for (int i = 0; i < max && !ok; i++) begin tick(1); if (busy === 1'b0) ok = 1'b1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(3);
    checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL reset_apple_valid got=%b exp=0", apple_valid); end
    checks++; if (apple_x !== 7'd0) begin failures++; $display("FAIL reset_apple_x got=%0d exp=0", apple_x); end
    checks++; if (apple_y !== 6'd0) begin failures++; $display("FAIL reset_apple_y got=%0d exp=0", apple_y); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (chk_req !== 1'b0) begin failures++; $display("FAIL reset_chk_req got=%b exp=0", chk_req); end
    checks++; if ({spawn_done, board_full} !== 2'b00) begin failures++; $display("FAIL reset_done_full got=%b exp=00", {spawn_done, board_full}); end
  endtask

  task automatic test_probe_wrap();
    int r0, d0;
    bit ok;
    mode = 1; lat = 2; r0 = n_req; d0 = n_done;
    rst = 1'b1; spawn_req = 1'b1;
    tick(1); spawn_req = 1'b0;
    checks++; if ({busy, chk_req} !== 2'b10) begin failures++; $display("FAIL wrap_draw_cycle busy_req got=%b exp=10", {busy, chk_req}); end
    tick(1);
    checks++; if (chk_req !== 1'b1) begin failures++; $display("FAIL wrap_latency chk_req got=%b exp=1", chk_req); end
    checks++; if ({chk_x, chk_y} !== {7'd39, 6'd29}) begin failures++; $display("FAIL wrap_first_query got=(%0d,%0d) exp=(39,29)", chk_x, chk_y); end
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_spawn_done got=timeout exp=pulse"); end
    checks++; if (n_req - r0 !== 2) begin failures++; $display("FAIL wrap_query_count got=%0d exp=2", n_req - r0); end
    checks++; if (qx.size() < r0 + 2 || {qx[r0+1], qy[r0+1]} !== 13'd0) begin failures++; $display("FAIL wrap_second_query got_count=%0d exp=(0,0)", qx.size() - r0); end
    checks++; if ({apple_valid, apple_x, apple_y} !== {1'b1, 13'd0}) begin failures++; $display("FAIL wrap_apple got=v%b (%0d,%0d) exp=v1 (0,0)", apple_valid, apple_x, apple_y); end
    tick(2);
    checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_free_board();
    int r0, d0;
    bit ok;
    mode = 0; lat = 2; r0 = n_req; d0 = n_done;
    pulse_spawn();
    checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL free_valid_cleared got=%b exp=0", apple_valid); end
    wait_done(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL free_spawn_done got=timeout exp=pulse"); end
    checks++; if (n_req - r0 !== 1) begin failures++; $display("FAIL free_query_count got=%0d exp=1", n_req - r0); end
    checks++; if (apple_x >= 7'd40 || apple_y >= 6'd30) begin failures++; $display("FAIL free_range got=(%0d,%0d) exp=<(40,30)", apple_x, apple_y); end
    checks++; if ({apple_x, apple_y} !== {cur_x, cur_y}) begin failures++; $display("FAIL free_apple_eq_query got=(%0d,%0d) exp=(%0d,%0d)", apple_x, apple_y, cur_x, cur_y); end
    tick(1);
    checks++; if ({spawn_done, apple_valid, busy} !== 3'b010) begin failures++; $display("FAIL free_after got=%b exp=010", {spawn_done, apple_valid, busy}); end
    tick(3);
    checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL free_done_count got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_full_board();
    int r0, d0;
    bit ok;
    mode = 2; lat = 1; r0 = n_req; d0 = n_done;
    pulse_spawn();
    wait_idle(5000, ok);
    tick(2);
    checks++; if (!ok) begin failures++; $display("FAIL full_idle got=timeout exp=idle"); end
    checks++; if (n_req - r0 !== 1200) begin failures++; $display("FAIL full_query_count got=%0d exp=1200", n_req - r0); end
    checks++; if ({board_full, apple_valid} !== 2'b10) begin failures++; $display("FAIL full_flags got=%b exp=10", {board_full, apple_valid}); end
    checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL full_no_done got=%0d exp=0", n_done - d0); end
    mode = 0; lat = 2;
    pulse_spawn();
    checks++; if ({board_full, busy} !== 2'b01) begin failures++; $display("FAIL full_clear got=%b exp=01", {board_full, busy}); end
    wait_done(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_recover got=timeout exp=pulse"); end
  endtask

  task automatic test_busy_ignored();
    int r0, d0;
    logic [6:0] ax;
    logic [5:0] ay;
    bit ok;
    mode = 0; lat = 4; r0 = n_req; d0 = n_done;
    pulse_spawn();
    wait_chk_req(60, ok);
    tick(1);
    pulse_spawn();
    wait_done(20, ok);
    tick(10);
    checks++; if (!ok) begin failures++; $display("FAIL busy_spawn_done got=timeout exp=pulse"); end
    checks++; if ({n_done - d0, n_req - r0} !== {32'd1, 32'd1}) begin failures++; $display("FAIL busy_single got=done%0d req%0d exp=done1 req1", n_done - d0, n_req - r0); end
    ax = apple_x; ay = apple_y; r0 = n_req; d0 = n_done;
    stray_done = 1'b1; tick(1); stray_done = 1'b0; tick(5);
    checks++; if ({busy, apple_valid, n_done - d0, n_req - r0} !== {2'b01, 64'd0}) begin failures++; $display("FAIL stray_state got=busy%b valid%b done%0d req%0d exp=busy0 valid1 done0 req0", busy, apple_valid, n_done - d0, n_req - r0); end
    checks++; if ({apple_x, apple_y} !== {ax, ay}) begin failures++; $display("FAIL stray_apple got=(%0d,%0d) exp=(%0d,%0d)", apple_x, apple_y, ax, ay); end
  endtask

  task automatic test_reset_mid_search();
    int d0;
    bit ok;
    mode = 0; lat = 6; d0 = n_done;
    pulse_spawn();
    wait_chk_req(60, ok);
    tick(1);
    rst = 1'b0; tick(1); rst = 1'b1;
    tick(10);
    checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", n_done - d0); end
    checks++; if ({busy, apple_valid, board_full, chk_req} !== 4'b0000) begin failures++; $display("FAIL midrst_flags got=%b exp=0000", {busy, apple_valid, board_full, chk_req}); end
    checks++; if ({apple_x, apple_y, chk_x, chk_y} !== 26'd0) begin failures++; $display("FAIL midrst_coords got=(%0d,%0d) chk=(%0d,%0d) exp=zeros", apple_x, apple_y, chk_x, chk_y); end
    lat = 2;
    pulse_spawn();
    wait_done(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_recover got=timeout exp=pulse"); end
  endtask

  initial begin
    checks = 0; failures = 0; mode = 0; lat = 2;
    rst = 1'b0; spawn_req = 1'b0; stray_done = 1'b0;
    test_reset();
    test_probe_wrap();
    test_free_board();
    test_full_board();
    test_busy_ignored();
    test_reset_mid_search();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
